// File: rtl/subneg_mem_arbiter.sv
// Shared 22x7 program/data store for the SUBNEG core and host loader: one access per clock, registered reads.
// Define SUBNEG_ARB_RR_EN for round-robin contention; otherwise the core has fixed priority.
module subneg_mem_arbiter #(
    parameter int DW    = 7,
    parameter int AW    = 5,
    parameter int DEPTH = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          oor_err,
    output logic [7:0]    conflicts
);

    logic [DW-1:0] mem [DEPTH];
    logic          acc_valid;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          in_range;
    logic [DW-1:0] rd_word;
    logic          contended;

    assign contended = core_req && host_req;

`ifdef SUBNEG_ARB_RR_EN
    typedef enum logic {PTR_CORE, PTR_HOST} rr_ptr_t;
    rr_ptr_t rr_ptr, rr_ptr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr <= PTR_CORE;
        else       rr_ptr <= rr_ptr_next;
    end

    // Pointer only moves on contention, and then points at the loser.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (contended)
            rr_ptr_next = (rr_ptr == PTR_CORE) ? PTR_HOST : PTR_CORE;
    end

    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!reset) begin
            if (core_req && (!host_req || rr_ptr == PTR_CORE)) core_gnt = 1'b1;
            else if (host_req)                                 host_gnt = 1'b1;
        end
    end
`else
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!reset) begin
            core_gnt = core_req;
            host_gnt = host_req && !core_req;
        end
    end
`endif

    always_comb begin
        acc_valid = core_gnt || host_gnt;
        acc_we    = core_gnt ? core_we    : host_we;
        acc_addr  = core_gnt ? core_addr  : host_addr;
        acc_wdata = core_gnt ? core_wdata : host_wdata;
        in_range  = int'(acc_addr) < DEPTH;
        rd_word   = '0;
        if (in_range) rd_word = mem[acc_addr];
    end

    // Out-of-range writes are silently dropped; oor_err reports them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (acc_valid && acc_we && in_range) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            core_rdata  <= '0;
            host_rdata  <= '0;
            oor_err     <= 1'b0;
        end else begin
            core_rvalid <= core_gnt && !core_we;
            host_rvalid <= host_gnt && !host_we;
            oor_err     <= acc_valid && !in_range;
            if (core_gnt && !core_we) core_rdata <= rd_word;
            if (host_gnt && !host_we) host_rdata <= rd_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              conflicts <= '0;
        else if (contended && conflicts != 8'hFF) conflicts <= conflicts + 8'd1;
    end

endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// Scoreboard bench for subneg_mem_arbiter; follows SUBNEG_ARB_RR_EN to pick the expected arbitration.
module tb_subneg_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       core_req, core_we, host_req, host_we;
    logic [4:0] core_addr, host_addr;
    logic [6:0] core_wdata, host_wdata;
    logic       core_gnt, core_rvalid, host_gnt, host_rvalid, oor_err;
    logic [6:0] core_rdata, host_rdata;
    logic [7:0] conflicts;

    int assert_count = 0;
    int fail_count   = 0;

    logic [6:0] m_mem [22];
    logic       m_ptr_host;
    int         m_conf;
    logic [6:0] m_core_rdata, m_host_rdata;
    logic [6:0] core_q [$];
    logic [6:0] host_q [$];

    subneg_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .oor_err(oor_err), .conflicts(conflicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 22; i++) m_mem[i] = '0;
        m_ptr_host   = 1'b0;
        m_conf       = 0;
        m_core_rdata = '0;
        m_host_rdata = '0;
        core_q.delete();
        host_q.delete();
    endtask

    // Model one granted access; returns 1 when it was out of range.
    task automatic modelAccess(input logic is_core, input logic we, input logic [4:0] addr,
                               input logic [6:0] wd, output logic oor);
        logic [6:0] rd;
        oor = (addr >= 5'd22);
        rd  = oor ? 7'd0 : m_mem[addr];
        if (we && !oor) m_mem[addr] = wd;
        if (!we) begin
            if (is_core) core_q.push_back(rd);
            else         host_q.push_back(rd);
        end
    endtask

    // One clock cycle: drive, check grants, advance the model, check registered outputs.
    task automatic applyStimulus(input logic creq, input logic cwe, input logic [4:0] caddr, input logic [6:0] cwd,
                                 input logic hreq, input logic hwe, input logic [4:0] haddr, input logic [6:0] hwd);
        logic egc, egh, e_crv, e_hrv, e_oor;
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
        #1;
`ifdef SUBNEG_ARB_RR_EN
        egc = creq && (!hreq || !m_ptr_host);
`else
        egc = creq;
`endif
        egh = hreq && !egc;
        checkOutput("core_gnt", 32'(core_gnt), 32'(egc));
        checkOutput("host_gnt", 32'(host_gnt), 32'(egh));
        if (creq && hreq) begin
            if (m_conf != 255) m_conf++;
            m_ptr_host = egc;
        end
        e_crv = egc && !cwe;
        e_hrv = egh && !hwe;
        e_oor = 1'b0;
        if (egc) modelAccess(1'b1, cwe, caddr, cwd, e_oor);
        if (egh) modelAccess(1'b0, hwe, haddr, hwd, e_oor);
        @(posedge clk);
        #1;
        checkOutput("core_rvalid", 32'(core_rvalid), 32'(e_crv));
        checkOutput("host_rvalid", 32'(host_rvalid), 32'(e_hrv));
        if (e_crv) m_core_rdata = core_q.pop_front();
        if (e_hrv) m_host_rdata = host_q.pop_front();
        checkOutput("core_rdata", 32'(core_rdata), 32'(m_core_rdata));
        checkOutput("host_rdata", 32'(host_rdata), 32'(m_host_rdata));
        checkOutput("oor_err", 32'(oor_err), 32'(e_oor));
        checkOutput("conflicts", 32'(conflicts), 32'(m_conf));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b0, 1'b0, 5'd0, 7'd0);
    endtask

    initial begin
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        modelClear();
        #12;
        checkOutput("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        checkOutput("rst_oor_err", 32'(oor_err), 32'd0);
        checkOutput("rst_conflicts", 32'(conflicts), 32'd0);
        checkOutput("rst_core_rdata", 32'(core_rdata), 32'd0);
        checkOutput("rst_host_rdata", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Host write 18 to addr 0, then read it back
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b1, 5'd0, 7'd18);
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b0, 5'd0, 7'd0);
        idle();

        // Four contended reads of addr 3, then core drops out
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 5'd3, 7'd0, 1'b1, 1'b0, 5'd3, 7'd0);
        applyStimulus(1'b0, 1'b0, 5'd3, 7'd0, 1'b1, 1'b0, 5'd3, 7'd0);
        idle();

        // Core writes 127 to addr 20, host reads it the next cycle
        applyStimulus(1'b1, 1'b1, 5'd20, 7'd127, 1'b0, 1'b0, 5'd0, 7'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b0, 5'd20, 7'd0);

        // Out-of-range write and read, then confirm neighbours untouched
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b1, 5'd25, 7'd99);
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b0, 5'd30, 7'd0);
        applyStimulus(1'b1, 1'b0, 5'd21, 7'd0, 1'b0, 1'b0, 5'd0, 7'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b0, 5'd31, 7'd0);
        applyStimulus(1'b1, 1'b1, 5'd22, 7'd5, 1'b0, 1'b0, 5'd0, 7'd0);

        // Mixed random traffic across the full address range
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          7'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 7'($urandom));

        // Sustained contention drives the counter into saturation
        for (int i = 0; i < 260; i++)
            applyStimulus(1'b1, 1'b0, 5'(i % 22), 7'd0, 1'b1, 1'b0, 5'(21 - (i % 22)), 7'd0);
        idle();

        // Make a nonzero word, read it so core_rvalid is high, then reset mid-access
        applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b1, 5'd7, 7'd77);
        applyStimulus(1'b1, 1'b0, 5'd7, 7'd0, 1'b0, 1'b0, 5'd0, 7'd0);
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'd7;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_core_gnt", 32'(core_gnt), 32'd0);
        checkOutput("rst_mid_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("rst_mid_core_rdata", 32'(core_rdata), 32'd0);
        checkOutput("rst_mid_conflicts", 32'(conflicts), 32'd0);
        core_req = 1'b0;
        #3;
        reset = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        checkOutput("post_rst_core_rvalid", 32'(core_rvalid), 32'd0);

        // Every word reads back zero after reset
        for (int a = 0; a < 22; a++)
            applyStimulus(1'b0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b0, 5'(a), 7'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
